// File: rtl/temp_plant.sv
// Behavioural room-temperature plant: a heater/cooler FSM moves Tact in
// prescaled unit steps, and Tact drifts toward ambient while idle.
module temp_plant #(
  parameter int WIDTH     = 8,
  parameter int HEAT_DIV  = 4,
  parameter int COOL_DIV  = 4,
  parameter int DRIFT_DIV = 16,
  parameter int T_INIT    = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Hon,
  input  logic             Con,
  input  logic [WIDTH-1:0] Tamb,
  input  logic             load,
  input  logic [WIDTH-1:0] Tload,
  output logic [WIDTH-1:0] Tact,
  output logic             heating,
  output logic             cooling,
  output logic             fault
);

  localparam int MAX_HC  = (HEAT_DIV > COOL_DIV) ? HEAT_DIV : COOL_DIV;
  localparam int MAX_DIV = (MAX_HC > DRIFT_DIV) ? MAX_HC : DRIFT_DIV;
  localparam int PW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

  localparam logic [PW-1:0]    HEAT_TC  = PW'(HEAT_DIV - 1);
  localparam logic [PW-1:0]    COOL_TC  = PW'(COOL_DIV - 1);
  localparam logic [PW-1:0]    DRIFT_TC = PW'(DRIFT_DIV - 1);
  localparam logic [PW-1:0]    P_ZERO   = PW'(0);
  localparam logic [PW-1:0]    P_ONE    = PW'(1);
  localparam logic [WIDTH-1:0] T_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] T_MIN    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] T_ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] T_RST    = WIDTH'(T_INIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HEAT  = 2'd1,
    COOL  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [PW-1:0]    presc_r, presc_nxt_s;
  logic [WIDTH-1:0] tact_r, tact_nxt_s;
  logic             heating_r, cooling_r, fault_r;
  logic             heating_s, cooling_s, fault_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; FAULT is only left through an all-off request
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FAULT: begin
        if ({Hon, Con} == 2'b00) state_nxt_s = IDLE;
        else                     state_nxt_s = FAULT;
      end
      default: begin
        case ({Hon, Con})
          2'b10:   state_nxt_s = HEAT;
          2'b01:   state_nxt_s = COOL;
          2'b11:   state_nxt_s = FAULT;
          default: state_nxt_s = IDLE;
        endcase
      end
    endcase
  end

  // Status flags follow the next state so they register alongside it
  always_comb begin
    heating_s = (state_nxt_s == HEAT);
    cooling_s = (state_nxt_s == COOL);
    fault_s   = (state_nxt_s == FAULT);
  end

  // Status flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heating_r <= 1'b0;
      cooling_r <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      heating_r <= heating_s;
      cooling_r <= cooling_s;
      fault_r   <= fault_s;
    end
  end

  // Prescaler and temperature step; load overrides any step in the same cycle
  always_comb begin
    presc_nxt_s = presc_r + P_ONE;
    tact_nxt_s  = tact_r;
    case (state_r)
      HEAT: begin
        if (presc_r == HEAT_TC) begin
          presc_nxt_s = P_ZERO;
          tact_nxt_s  = (tact_r == T_MAX) ? T_MAX : tact_r + T_ONE;
        end else begin
          tact_nxt_s  = tact_r;
        end
      end
      COOL: begin
        if (presc_r == COOL_TC) begin
          presc_nxt_s = P_ZERO;
          tact_nxt_s  = (tact_r == T_MIN) ? T_MIN : tact_r - T_ONE;
        end else begin
          tact_nxt_s  = tact_r;
        end
      end
      IDLE: begin
        if (presc_r == DRIFT_TC) begin
          presc_nxt_s = P_ZERO;
          if (tact_r < Tamb)      tact_nxt_s = tact_r + T_ONE;
          else if (tact_r > Tamb) tact_nxt_s = tact_r - T_ONE;
          else                    tact_nxt_s = tact_r;
        end else begin
          tact_nxt_s  = tact_r;
        end
      end
      default: begin
        presc_nxt_s = P_ZERO;
        tact_nxt_s  = tact_r;
      end
    endcase
    if (load) begin
      presc_nxt_s = P_ZERO;
      tact_nxt_s  = Tload;
    end else if (state_nxt_s != state_r) begin
      presc_nxt_s = P_ZERO;
    end else begin
      presc_nxt_s = presc_nxt_s;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= P_ZERO;
      tact_r  <= T_RST;
    end else begin
      presc_r <= presc_nxt_s;
      tact_r  <= tact_nxt_s;
    end
  end

  assign Tact    = tact_r;
  assign heating = heating_r;
  assign cooling = cooling_r;
  assign fault   = fault_r;

endmodule

// File: doc/temp_plant.md
TEMP_PLANT -- requirements
Module: temp_plant

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the temperature word width in bits.
REQ-002 SHALL have parameter HEAT_DIV, default 4, giving clk cycles per +1 step while heating.
REQ-003 SHALL have parameter COOL_DIV, default 4, giving clk cycles per -1 step while cooling.
REQ-004 SHALL have parameter DRIFT_DIV, default 16, giving clk cycles per 1-step drift toward ambient while idle.
REQ-005 SHALL have parameter T_INIT, default 20, giving the Tact reset value.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port Hon, input, 1 bit: heater request from the thermostat.
REQ-009 SHALL have port Con, input, 1 bit: cooler request from the thermostat.
REQ-010 SHALL have port Tamb, input, WIDTH bits: unsigned ambient temperature.
REQ-011 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-012 SHALL have port Tload, input, WIDTH bits: value written to Tact when load=1.
REQ-013 SHALL have port Tact, output, WIDTH bits: registered, unsigned modelled room temperature.
REQ-014 SHALL have port heating, output, 1 bit: registered; 1 while the state is HEAT.
REQ-015 SHALL have port cooling, output, 1 bit: registered; 1 while the state is COOL.
REQ-016 SHALL have port fault, output, 1 bit: registered; 1 while the state is FAULT.

Function
REQ-017 SHALL implement a four-state FSM with states IDLE, HEAT, COOL and FAULT, using a single prescaler counter wide enough for max(HEAT_DIV, COOL_DIV, DRIFT_DIV)-1.
REQ-018 SHALL evaluate next-state every cycle from the sampled {Hon,Con}: 10 -> HEAT, 01 -> COOL, 11 -> FAULT, 00 -> IDLE.
REQ-019 SHALL, once in FAULT, remain there until {Hon,Con}=00 is sampled, then go to IDLE; the values 10 and 01 SHALL NOT exit FAULT.
REQ-020 SHALL clear the prescaler to 0 on any state change and on load; otherwise it increments each cycle.
REQ-021 SHALL, in HEAT when the prescaler reaches HEAT_DIV-1, set Tact to Tact+1, saturating at 2^WIDTH-1, and return the prescaler to 0.
REQ-022 SHALL, in COOL when the prescaler reaches COOL_DIV-1, set Tact to Tact-1, saturating at 0, and return the prescaler to 0.
REQ-023 SHALL, in IDLE when the prescaler reaches DRIFT_DIV-1, move Tact one step toward Tamb: +1 if Tact<Tamb, -1 if Tact>Tamb, unchanged if equal.
REQ-024 SHALL, in FAULT, hold Tact and keep the prescaler at 0.
REQ-025 SHALL, when load=1, set Tact to Tload on that edge, overriding any step or drift in the same cycle; the FSM still transitions normally.
REQ-026 SHALL perform all arithmetic unsigned in WIDTH bits with explicit saturation; Tact SHALL never wrap.
REQ-027 SHALL drive heating, cooling and fault from the registered state, so they change one cycle after the input change is sampled.
REQ-028 SHALL update the first Tact step in a new HEAT or COOL state exactly DIV cycles after entry, where DIV is HEAT_DIV or COOL_DIV respectively.
REQ-029 SHALL keep heating, cooling and fault mutually exclusive (one-hot or all zero).

Reset
REQ-030 SHALL, on rst_n=0 and asynchronously regardless of clk, set Tact=T_INIT, state=IDLE, prescaler=0 and heating=cooling=fault=0.
REQ-031 SHALL, if reset occurs mid-step, discard any partial prescaler count; after deassertion the first drift step occurs DRIFT_DIV cycles after the first active edge.
REQ-032 SHALL sample load and {Hon,Con} only on the first rising clk edge after rst_n=1.

Verification
REQ-033 SHALL verify heat ramp: reset, Hon=1, Con=0 for 40 cycles -> heating=1 after 1 cycle, Tact 20->30 in +1 steps every 4 cycles.
REQ-034 SHALL verify cool saturation: load Tload=2, then Con=1 for 20 cycles -> Tact reaches 0 after 8 cycles and holds at 0, cooling=1.
REQ-035 SHALL verify heat saturation: load Tload=254, then Hon=1 for 16 cycles -> Tact reaches 255 and holds, no wrap to 0.
REQ-036 SHALL verify drift: Tamb=25, Tact=20, Hon=Con=0 for 80 cycles -> Tact=25 after 80 cycles and stays 25 thereafter.
REQ-037 SHALL verify fault: Hon=Con=1 -> fault=1 and Tact frozen; then Hon=1, Con=0 -> remains FAULT; then 00 -> IDLE next cycle, fault=0.
REQ-038 SHALL verify async reset: assert rst_n=0 mid-HEAT between clock edges -> Tact=20 and heating=0 immediately, without waiting for a clk edge.
